// File: rtl/boot_pkg.sv
// Shared types and framing constants for the byte-stream program loader.
// Used by the loader FSM and by the byte packer.
package boot_pkg;

   typedef enum logic [2:0] {
      ST_LEN,
      ST_DATA,
      ST_CSUM,
      ST_DONE,
      ST_ERROR
   } state_t;

   localparam int HDR_BYTES  = 3;
   localparam int WORD_BYTES = 3;
   localparam int WORD_W     = 24;

endpackage

// File: rtl/bootloader_if.sv
// Byte-stream receive link and instruction-memory write port of the loader.
// The loader is the slave of the byte link and the master of the memory port.
interface boot_rx_if;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ready;

   modport master (output rx_data, output rx_valid, input rx_ready);
   modport slave  (input rx_data, input rx_valid, output rx_ready);
endinterface

interface boot_mem_if;
   logic        mem_we;
   logic [23:0] mem_addr;
   logic [23:0] mem_wdata;

   modport master (output mem_we, output mem_addr, output mem_wdata);
   modport slave  (input mem_we, input mem_addr, input mem_wdata);
endinterface

// File: rtl/boot_byte_packer.sv
// Little-endian byte-to-word packer: the first byte of a group lands in bits 7:0.
// word/word_valid are combinational on the final byte so the caller can register them.
module boot_byte_packer
   import boot_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr,
   input  logic [7:0]        din,
   input  logic              stb,
   output logic [WORD_W-1:0] word,
   output logic              word_valid
);

   logic [1:0]        cnt;
   logic [WORD_W-9:0] sr;

   assign word       = {din, sr};
   assign word_valid = stb && (cnt == 2'(WORD_BYTES - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
         sr  <= '0;
      end else if (clr) begin
         cnt <= '0;
         sr  <= '0;
      end else if (stb) begin
         sr  <= {din, sr[WORD_W-9:8]};
         cnt <= word_valid ? 2'd0 : cnt + 2'd1;
      end
   end

endmodule

// File: rtl/bootloader.sv
// Framed program loader: header count, little-endian 24-bit words, XOR checksum.
// Holds the core in reset until a complete image with a matching checksum is loaded.
module bootloader
   import boot_pkg::*;
#(
   parameter logic [23:0] BASE_ADDR = 24'h000000,
   parameter int          MAX_WORDS = 4096
) (
   input  logic       clk,
   input  logic       rst_n,
   boot_rx_if.slave   rx,
   boot_mem_if.master mem,
   input  logic       start,
   output logic       core_rst,
   output logic       done,
   output logic       error
);

   localparam logic [WORD_W-1:0] MAX_N = WORD_W'(MAX_WORDS);

   state_t            state;
   logic [WORD_W-1:0] idx;
   logic [WORD_W-1:0] n_words;
   logic [7:0]        xsum;

   logic              hs;
   logic              pk_clr;
   logic              pk_stb;
   logic              pk_valid;
   logic [WORD_W-1:0] pk_word;

   assign hs     = rx.rx_valid && rx.rx_ready;
   assign pk_clr = start && (state == ST_DONE || state == ST_ERROR);
   assign pk_stb = hs && (state == ST_LEN || state == ST_DATA);

   // One packer serves both the header count and the payload words.
   boot_byte_packer u_packer (
      .clk        (clk),
      .rst_n      (rst_n),
      .clr        (pk_clr),
      .din        (rx.rx_data),
      .stb        (pk_stb),
      .word       (pk_word),
      .word_valid (pk_valid)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= ST_LEN;
         core_rst      <= 1'b1;
         rx.rx_ready   <= 1'b0;
         mem.mem_we    <= 1'b0;
         mem.mem_addr  <= '0;
         mem.mem_wdata <= '0;
         done          <= 1'b0;
         error         <= 1'b0;
         idx           <= '0;
         n_words       <= '0;
         xsum          <= '0;
      end else begin
         mem.mem_we <= 1'b0;
         case (state)
            ST_LEN: begin
               rx.rx_ready <= 1'b1;
               if (hs) xsum <= xsum ^ rx.rx_data;
               if (pk_valid) begin
                  n_words <= pk_word;
                  if (pk_word == '0) begin
                     state <= ST_CSUM;
                  end else if (pk_word > MAX_N) begin
                     state       <= ST_ERROR;
                     error       <= 1'b1;
                     rx.rx_ready <= 1'b0;
                  end else begin
                     state <= ST_DATA;
                  end
               end
            end
            ST_DATA: begin
               if (hs) xsum <= xsum ^ rx.rx_data;
               if (pk_valid) begin
                  mem.mem_we    <= 1'b1;
                  mem.mem_addr  <= BASE_ADDR + idx;
                  mem.mem_wdata <= pk_word;
                  idx           <= idx + 1'b1;
                  if (idx == n_words - 1'b1) state <= ST_CSUM;
               end
            end
            ST_CSUM: begin
               if (hs) begin
                  rx.rx_ready <= 1'b0;
                  if (rx.rx_data == xsum) begin
                     state    <= ST_DONE;
                     done     <= 1'b1;
                     core_rst <= 1'b0;
                  end else begin
                     state <= ST_ERROR;
                     error <= 1'b1;
                  end
               end
            end
            ST_DONE, ST_ERROR: begin
               if (start) begin
                  state       <= ST_LEN;
                  core_rst    <= 1'b1;
                  done        <= 1'b0;
                  error       <= 1'b0;
                  rx.rx_ready <= 1'b1;
                  idx         <= '0;
                  xsum        <= '0;
               end
            end
            default: state <= ST_LEN;
         endcase
      end
   end

endmodule

// File: tb/tb_bootloader.sv
// Scoreboard bench for bootloader: two instances cover base 0 / large limit and
// base 24'hFFFFFF / MAX_WORDS=4 (oversize header and address wrap).
module tb_bootloader;

   typedef struct {
      int          kind;   // 0 write, 1 done rise, 2 error rise
      logic [23:0] addr;
      logic [23:0] data;
   } exp_t;

   logic clk = 1'b0;
   logic rst_a_n, rst_b_n;
   logic start_a, start_b;
   logic crst_a, crst_b, done_a, done_b, err_a, err_b;

   boot_rx_if  rxa ();
   boot_rx_if  rxb ();
   boot_mem_if ma ();
   boot_mem_if mb ();

   bootloader #(.BASE_ADDR(24'h000000), .MAX_WORDS(4096)) dut_a (
      .clk(clk), .rst_n(rst_a_n), .rx(rxa), .mem(ma), .start(start_a),
      .core_rst(crst_a), .done(done_a), .error(err_a));

   bootloader #(.BASE_ADDR(24'hFFFFFF), .MAX_WORDS(4)) dut_b (
      .clk(clk), .rst_n(rst_b_n), .rx(rxb), .mem(mb), .start(start_b),
      .core_rst(crst_b), .done(done_b), .error(err_b));

   always #5 clk = ~clk;

   int   total = 0;
   int   bad   = 0;
   exp_t qa[$];
   exp_t qb[$];
   logic [23:0] wbuf [4];
   logic pd_a = 1'b0, pe_a = 1'b0, pd_b = 1'b0, pe_b = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic f_rdy(int sel);  return sel ? rxb.rx_ready : rxa.rx_ready; endfunction
   function automatic logic f_we(int sel);   return sel ? mb.mem_we : ma.mem_we;         endfunction
   function automatic logic f_done(int sel); return sel ? done_b : done_a;               endfunction
   function automatic logic f_err(int sel);  return sel ? err_b : err_a;                 endfunction
   function automatic logic f_crst(int sel); return sel ? crst_b : crst_a;               endfunction

   task automatic push(input int sel, input int kind, input logic [23:0] addr, input logic [23:0] data);
      exp_t e;
      e.kind = kind; e.addr = addr; e.data = data;
      if (sel == 0) qa.push_back(e); else qb.push_back(e);
   endtask

   task automatic sb_pop(input int sel, input int kind, input logic [23:0] addr, input logic [23:0] data);
      exp_t e;
      if ((sel == 0 && qa.size() == 0) || (sel == 1 && qb.size() == 0)) begin
         total++; bad++;
         $display("FAIL sb%0d_unexpected: got event kind %0d addr %h data %h, expected none", sel, kind, addr, data);
      end else begin
         e = (sel == 0) ? qa.pop_front() : qb.pop_front();
         chk($sformatf("sb%0d_kind", sel), kind, e.kind);
         if (e.kind == 0 && kind == 0) begin
            chk($sformatf("sb%0d_addr", sel), {8'h0, addr}, {8'h0, e.addr});
            chk($sformatf("sb%0d_data", sel), {8'h0, data}, {8'h0, e.data});
         end
      end
   endtask

   // Monitors: every write strobe and every done/error rising edge consumes one entry.
   always @(negedge clk) begin
      if (ma.mem_we) sb_pop(0, 0, ma.mem_addr, ma.mem_wdata);
      if (done_a && !pd_a) sb_pop(0, 1, 24'h0, 24'h0);
      if (err_a && !pe_a)  sb_pop(0, 2, 24'h0, 24'h0);
      pd_a = done_a; pe_a = err_a;
   end

   always @(negedge clk) begin
      if (mb.mem_we) sb_pop(1, 0, mb.mem_addr, mb.mem_wdata);
      if (done_b && !pd_b) sb_pop(1, 1, 24'h0, 24'h0);
      if (err_b && !pe_b)  sb_pop(1, 2, 24'h0, 24'h0);
      pd_b = done_b; pe_b = err_b;
   end

   // Called #1 after a clock edge; returns #1 after the handshake edge.
   task automatic send_byte(input int sel, input logic [7:0] b, input bit gap);
      int waited = 0;
      if (gap) repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
      if (sel == 0) begin rxa.rx_data = b; rxa.rx_valid = 1'b1; end
      else          begin rxb.rx_data = b; rxb.rx_valid = 1'b1; end
      while (!f_rdy(sel) && waited < 20) begin @(posedge clk); #1; waited++; end
      if (!f_rdy(sel)) chk("rx_ready_timeout", 32'(f_rdy(sel)), 32'd1);
      @(posedge clk); #1;
      if (sel == 0) rxa.rx_valid = 1'b0; else rxb.rx_valid = 1'b0;
   endtask

   task automatic send_frame(input int sel, input logic [23:0] n, input int ndata,
                             input bit send_csum, input logic [7:0] flip,
                             input bit gap, input bit hdr_err);
      logic [7:0]  x = 8'h00;
      logic [7:0]  b;
      logic [23:0] w;
      logic [23:0] base = (sel != 0) ? 24'hFFFFFF : 24'h000000;
      if (hdr_err) push(sel, 2, 24'h0, 24'h0);
      for (int i = 0; i < 3; i++) begin
         b = n[8*i +: 8];
         x ^= b;
         send_byte(sel, b, gap);
      end
      if (hdr_err) begin
         chk("oversize_error", 32'(f_err(sel)), 32'd1);
         chk("oversize_core_rst", 32'(f_crst(sel)), 32'd1);
         chk("oversize_rx_ready", 32'(f_rdy(sel)), 32'd0);
         return;
      end
      for (int k = 0; k < ndata; k++) begin
         w = wbuf[k/3];
         b = w[8*(k%3) +: 8];
         x ^= b;
         if (k % 3 == 2) push(sel, 0, 24'(base + 24'(k/3)), w);
         send_byte(sel, b, gap);
         if (k % 3 == 2) chk("we_timing", 32'(f_we(sel)), 32'd1);
      end
      if (send_csum) begin
         push(sel, (flip == 8'h00) ? 1 : 2, 24'h0, 24'h0);
         send_byte(sel, x ^ flip, gap);
         chk("csum_done",     32'(f_done(sel)), (flip == 8'h00) ? 32'd1 : 32'd0);
         chk("csum_error",    32'(f_err(sel)),  (flip == 8'h00) ? 32'd0 : 32'd1);
         chk("csum_core_rst", 32'(f_crst(sel)), (flip == 8'h00) ? 32'd0 : 32'd1);
         chk("csum_rx_ready", 32'(f_rdy(sel)),  32'd0);
      end
   endtask

   task automatic pulse_start(input int sel);
      if (sel == 0) start_a = 1'b1; else start_b = 1'b1;
      @(posedge clk); #1;
      if (sel == 0) start_a = 1'b0; else start_b = 1'b0;
      chk("restart_core_rst", 32'(f_crst(sel)), 32'd1);
      chk("restart_done",     32'(f_done(sel)), 32'd0);
      chk("restart_error",    32'(f_err(sel)),  32'd0);
      chk("restart_rx_ready", 32'(f_rdy(sel)),  32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_a_n = 1'b1; rst_b_n = 1'b1;
      start_a = 1'b0; start_b = 1'b0;
      rxa.rx_valid = 1'b0; rxa.rx_data = 8'h00;
      rxb.rx_valid = 1'b0; rxb.rx_data = 8'h00;
      #2;
      rst_a_n = 1'b0; rst_b_n = 1'b0;
      @(posedge clk); @(posedge clk); #1;
      chk("rst_core_rst", 32'(crst_a), 32'd1);
      chk("rst_rx_ready", 32'(rxa.rx_ready), 32'd0);
      chk("rst_mem_we",   32'(ma.mem_we), 32'd0);
      chk("rst_mem_addr", {8'h0, ma.mem_addr}, 32'd0);
      chk("rst_done_err", {30'h0, done_a, err_a}, 32'd0);
      rst_a_n = 1'b1; rst_b_n = 1'b1;
      @(posedge clk); #1;
      chk("post_rst_rx_ready", 32'(rxa.rx_ready), 32'd1);

      // Nominal two-word load.
      wbuf[0] = 24'h123456; wbuf[1] = 24'hABCDEF;
      send_frame(0, 24'd2, 6, 1'b1, 8'h00, 1'b0, 1'b0);
      pulse_start(0);

      // Same frame, corrupted checksum.
      send_frame(0, 24'd2, 6, 1'b1, 8'h01, 1'b0, 1'b0);
      pulse_start(0);

      // Empty image.
      send_frame(0, 24'd0, 0, 1'b1, 8'h00, 1'b0, 1'b0);
      pulse_start(0);

      // Reset after four payload bytes, then a clean reload.
      send_frame(0, 24'd2, 4, 1'b0, 8'h00, 1'b0, 1'b0);
      rst_a_n = 1'b0;
      #1;
      chk("midrst_core_rst", 32'(crst_a), 32'd1);
      chk("midrst_rx_ready", 32'(rxa.rx_ready), 32'd0);
      chk("midrst_mem_we",   32'(ma.mem_we), 32'd0);
      @(posedge clk); #1;
      rst_a_n = 1'b1;
      send_frame(0, 24'd2, 6, 1'b1, 8'h00, 1'b0, 1'b0);
      pulse_start(0);

      // Oversize header on the MAX_WORDS=4 instance.
      send_frame(1, 24'd5, 0, 1'b0, 8'h00, 1'b0, 1'b1);
      pulse_start(1);

      // Gapped stream with address wrap from 24'hFFFFFF.
      wbuf[0] = 24'h0A0B0C; wbuf[1] = 24'h77FF01;
      send_frame(1, 24'd2, 6, 1'b1, 8'h00, 1'b1, 1'b0);

      repeat (4) @(posedge clk);
      #1;
      chk("sb0_leftover", qa.size(), 32'd0);
      chk("sb1_leftover", qb.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
